wb_gain: RTL and testbench



---
 rtl/wb_gain.sv | 134 +++++++++++++
 tb/tb_wb_gain.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/wb_gain.sv
// rtl/wb_gain.sv - per-channel black-level subtract, Q2.8 gain, round and saturate
// Shadowed config registers swap into the active set on frame_start.
module wb_gain #(
  parameter int DW       = 12,
  parameter int GW       = 10,
  parameter int GAIN_RST = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [1:0]    cfg_addr,
  input  logic [15:0]   cfg_wdata,
  output logic          cfg_pending,
  input  logic          frame_start,
  input  logic          inpvalid,
  input  logic [DW-1:0] din0,
  input  logic [DW-1:0] din1,
  input  logic [DW-1:0] din2,
  output logic          outvalid,
  output logic [DW-1:0] dout0,
  output logic [DW-1:0] dout1,
  output logic [DW-1:0] dout2
);

  localparam int PW = DW + GW;
  localparam int RW = PW - 7;

  logic [GW-1:0] gain_sh_q  [3];
  logic [GW-1:0] gain_sh_d  [3];
  logic [GW-1:0] gain_act_q [3];
  logic [GW-1:0] gain_act_d [3];
  logic [DW-1:0] black_sh_q, black_sh_d;
  logic [DW-1:0] black_act_q, black_act_d;
  logic          pending_q, pending_d;

  logic          v1_q, v1_d;
  logic [DW-1:0] x_q  [3];
  logic [DW-1:0] x_d  [3];
  logic [GW-1:0] g1_q [3];
  logic [GW-1:0] g1_d [3];
  logic          v2_q, v2_d;
  logic [PW-1:0] p_q  [3];
  logic [PW-1:0] p_d  [3];
  logic          v3_q, v3_d;
  logic [DW-1:0] dout_q [3];
  logic [DW-1:0] dout_d [3];

  logic [DW-1:0] din_w [3];
  logic [RW-1:0] r_w   [3];
  logic          unused_wdata;

  assign din_w[0] = din0;
  assign din_w[1] = din1;
  assign din_w[2] = din2;
  assign unused_wdata = &{1'b0, cfg_wdata[15:DW]};

  always_comb begin
    gain_sh_d   = gain_sh_q;
    gain_act_d  = gain_act_q;
    black_sh_d  = black_sh_q;
    black_act_d = black_act_q;
    pending_d   = pending_q;
    v1_d        = inpvalid;
    x_d         = x_q;
    g1_d        = g1_q;
    v2_d        = v1_q;
    p_d         = p_q;
    v3_d        = v2_q;
    dout_d      = dout_q;
    for (int i = 0; i < 3; i++) r_w[i] = '0;

    // Active set copies the pre-write shadow so a same-cycle write stays pending.
    if (frame_start) begin
      gain_act_d  = gain_sh_q;
      black_act_d = black_sh_q;
      pending_d   = 1'b0;
    end
    if (cfg_we) begin
      pending_d = 1'b1;
      if (cfg_addr == 2'd3) black_sh_d = cfg_wdata[DW-1:0];
      else                  gain_sh_d[cfg_addr] = cfg_wdata[GW-1:0];
    end

    for (int i = 0; i < 3; i++) begin
      // Gain travels with the pixel so a frame_start cycle pixel keeps the old set.
      if (inpvalid) begin
        x_d[i]  = (din_w[i] > black_act_q) ? din_w[i] - black_act_q : '0;
        g1_d[i] = gain_act_q[i];
      end
      if (v1_q) p_d[i] = PW'(x_q[i]) * PW'(g1_q[i]);
      r_w[i] = RW'(({1'b0, p_q[i]} + (PW+1)'(128)) >> 8);
      if (v2_q) dout_d[i] = (|r_w[i][RW-1:DW]) ? {DW{1'b1}} : r_w[i][DW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        gain_sh_q[i]  <= GW'(GAIN_RST);
        gain_act_q[i] <= GW'(GAIN_RST);
        x_q[i]        <= '0;
        g1_q[i]       <= '0;
        p_q[i]        <= '0;
        dout_q[i]     <= '0;
      end
      black_sh_q  <= '0;
      black_act_q <= '0;
      pending_q   <= 1'b0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      v3_q        <= 1'b0;
    end else begin
      gain_sh_q   <= gain_sh_d;
      gain_act_q  <= gain_act_d;
      black_sh_q  <= black_sh_d;
      black_act_q <= black_act_d;
      pending_q   <= pending_d;
      v1_q        <= v1_d;
      x_q         <= x_d;
      g1_q        <= g1_d;
      v2_q        <= v2_d;
      p_q         <= p_d;
      v3_q        <= v3_d;
      dout_q      <= dout_d;
    end
  end

  assign cfg_pending = pending_q;
  assign outvalid    = v3_q;
  assign dout0       = dout_q[0];
  assign dout1       = dout_q[1];
  assign dout2       = dout_q[2];

endmodule

// File: tb/tb_wb_gain.sv
// tb/tb_wb_gain.sv - directed bench for wb_gain
module tb_wb_gain;

  logic        clk;
  logic        rst;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic        cfg_pending;
  logic        frame_start;
  logic        inpvalid;
  logic [11:0] din0, din1, din2;
  logic        outvalid;
  logic [11:0] dout0, dout1, dout2;

  int n_checks = 0;
  int n_fail   = 0;

  logic        r_ov_early, r_ov;
  logic [11:0] r_d0, r_d1, r_d2;

  wb_gain dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_pending(cfg_pending), .frame_start(frame_start),
    .inpvalid(inpvalid), .din0(din0), .din1(din1), .din2(din2),
    .outvalid(outvalid), .dout0(dout0), .dout1(dout1), .dout2(dout2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic send1(input logic [11:0] a, input logic [11:0] b, input logic [11:0] c);
    inpvalid = 1'b1; din0 = a; din1 = b; din2 = c;
    @(negedge clk);
    inpvalid = 1'b0;
    @(negedge clk);
    r_ov_early = outvalid;
    @(negedge clk);
    r_ov = outvalid; r_d0 = dout0; r_d1 = dout1; r_d2 = dout2;
  endtask

  task automatic wr_cfg(input logic [1:0] a, input logic [15:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++; if (outvalid !== 1'b0) begin n_fail++; $display("FAIL reset_outvalid got %0b want 0", outvalid); end
    n_checks++; if ({dout0, dout1, dout2} !== 36'd0) begin n_fail++; $display("FAIL reset_dout got %0d/%0d/%0d want 0/0/0", dout0, dout1, dout2); end
    n_checks++; if (cfg_pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending got %0b want 0", cfg_pending); end
  endtask

  task automatic test_unity();
    send1(12'd100, 12'd2000, 12'd4095);
    n_checks++; if (r_ov_early !== 1'b0) begin n_fail++; $display("FAIL unity_early_valid got %0b want 0", r_ov_early); end
    n_checks++; if (r_ov !== 1'b1) begin n_fail++; $display("FAIL unity_outvalid got %0b want 1", r_ov); end
    n_checks++; if (r_d0 !== 12'd100 || r_d1 !== 12'd2000 || r_d2 !== 12'd4095) begin
      n_fail++; $display("FAIL unity_dout got %0d/%0d/%0d want 100/2000/4095", r_d0, r_d1, r_d2); end
    n_checks++; if (cfg_pending !== 1'b0) begin n_fail++; $display("FAIL unity_pending got %0b want 0", cfg_pending); end
  endtask

  task automatic test_gains();
    wr_cfg(2'd0, 16'd384);
    n_checks++; if (cfg_pending !== 1'b1) begin n_fail++; $display("FAIL gains_pending_set got %0b want 1", cfg_pending); end
    wr_cfg(2'd1, 16'd512);
    wr_cfg(2'd2, 16'd257);
    pulse_frame();
    n_checks++; if (cfg_pending !== 1'b0) begin n_fail++; $display("FAIL gains_pending_clr got %0b want 0", cfg_pending); end
    send1(12'd1000, 12'd3000, 12'd128);
    n_checks++; if (r_ov !== 1'b1 || r_d0 !== 12'd1500 || r_d1 !== 12'd4095 || r_d2 !== 12'd129) begin
      n_fail++; $display("FAIL gains_dout got v%0b %0d/%0d/%0d want v1 1500/4095/129", r_ov, r_d0, r_d1, r_d2); end
  endtask

  task automatic test_boundaries();
    wr_cfg(2'd0, 16'd0);
    wr_cfg(2'd1, 16'd1023);
    wr_cfg(2'd2, 16'd1023);
    pulse_frame();
    send1(12'd4095, 12'd4095, 12'd1);
    n_checks++; if (r_d0 !== 12'd0 || r_d1 !== 12'd4095 || r_d2 !== 12'd4) begin
      n_fail++; $display("FAIL bound_dout got %0d/%0d/%0d want 0/4095/4", r_d0, r_d1, r_d2); end
  endtask

  task automatic test_back_to_back();
    wr_cfg(2'd0, 16'd256);
    wr_cfg(2'd1, 16'd256);
    wr_cfg(2'd2, 16'd256);
    wr_cfg(2'd3, 16'd64);
    pulse_frame();
    din1 = 12'd0; din2 = 12'd0;
    inpvalid = 1'b1; din0 = 12'd1064; @(negedge clk);
    din0 = 12'd64; @(negedge clk);
    din0 = 12'd50; @(negedge clk);
    inpvalid = 1'b0;
    n_checks++; if (outvalid !== 1'b1 || dout0 !== 12'd1000) begin n_fail++; $display("FAIL b2b_px0 got v%0b %0d want v1 1000", outvalid, dout0); end
    @(negedge clk);
    n_checks++; if (outvalid !== 1'b1 || dout0 !== 12'd0) begin n_fail++; $display("FAIL b2b_px1 got v%0b %0d want v1 0", outvalid, dout0); end
    @(negedge clk);
    n_checks++; if (outvalid !== 1'b1 || dout0 !== 12'd0) begin n_fail++; $display("FAIL b2b_px2 got v%0b %0d want v1 0", outvalid, dout0); end
    @(negedge clk);
    n_checks++; if (outvalid !== 1'b0) begin n_fail++; $display("FAIL b2b_tail got %0b want 0", outvalid); end
  endtask

  task automatic test_midframe();
    wr_cfg(2'd3, 16'd0);
    pulse_frame();
    inpvalid = 1'b1; din0 = 12'd800; din1 = 12'd0; din2 = 12'd0;
    cfg_we = 1'b1; cfg_addr = 2'd0; cfg_wdata = 16'd128;
    @(negedge clk);
    inpvalid = 1'b0; cfg_we = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (outvalid !== 1'b1 || dout0 !== 12'd800) begin n_fail++; $display("FAIL midframe_hold got v%0b %0d want v1 800", outvalid, dout0); end
    n_checks++; if (cfg_pending !== 1'b1) begin n_fail++; $display("FAIL midframe_pending got %0b want 1", cfg_pending); end
    pulse_frame();
    send1(12'd800, 12'd0, 12'd0);
    n_checks++; if (r_d0 !== 12'd400) begin n_fail++; $display("FAIL midframe_next got %0d want 400", r_d0); end
  endtask

  task automatic test_simultaneous();
    wr_cfg(2'd1, 16'd320);
    cfg_we = 1'b1; cfg_addr = 2'd1; cfg_wdata = 16'd512; frame_start = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0; frame_start = 1'b0;
    n_checks++; if (cfg_pending !== 1'b1) begin n_fail++; $display("FAIL simul_pending got %0b want 1", cfg_pending); end
    send1(12'd0, 12'd100, 12'd0);
    n_checks++; if (r_d1 !== 12'd125) begin n_fail++; $display("FAIL simul_gain1 got %0d want 125", r_d1); end
    pulse_frame();
    n_checks++; if (cfg_pending !== 1'b0) begin n_fail++; $display("FAIL simul_pending_clr got %0b want 0", cfg_pending); end
    send1(12'd0, 12'd100, 12'd0);
    n_checks++; if (r_d1 !== 12'd200) begin n_fail++; $display("FAIL simul_next got %0d want 200", r_d1); end
  endtask

  task automatic test_reset_midstream();
    wr_cfg(2'd2, 16'd999);
    for (int i = 0; i < 6; i++) begin
      if (i == 5) begin
        n_checks++; if (outvalid !== 1'b1) begin n_fail++; $display("FAIL rst_stream_valid got %0b want 1", outvalid); end
        rst = 1'b1;
      end
      inpvalid = 1'b1; din0 = 12'(300 + i); din1 = 12'd7; din2 = 12'd9;
      @(negedge clk);
    end
    rst = 1'b0; inpvalid = 1'b0;
    n_checks++; if ({dout0, dout1, dout2} !== 36'd0) begin n_fail++; $display("FAIL rst_dout got %0d/%0d/%0d want 0/0/0", dout0, dout1, dout2); end
    n_checks++; if (cfg_pending !== 1'b0) begin n_fail++; $display("FAIL rst_pending got %0b want 0", cfg_pending); end
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (outvalid !== 1'b0) begin n_fail++; $display("FAIL rst_stale_valid cycle %0d got %0b want 0", i, outvalid); end
      @(negedge clk);
    end
    send1(12'd100, 12'd2000, 12'd300);
    n_checks++; if (r_ov_early !== 1'b0 || r_ov !== 1'b1) begin n_fail++; $display("FAIL rst_latency got early %0b final %0b want 0/1", r_ov_early, r_ov); end
    n_checks++; if (r_d0 !== 12'd100 || r_d1 !== 12'd2000 || r_d2 !== 12'd300) begin
      n_fail++; $display("FAIL rst_unity got %0d/%0d/%0d want 100/2000/300", r_d0, r_d1, r_d2); end
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 16'd0;
    frame_start = 1'b0; inpvalid = 1'b0; din0 = 12'd0; din1 = 12'd0; din2 = 12'd0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_unity();
    test_gains();
    test_boundaries();
    test_back_to_back();
    test_midframe();
    test_simultaneous();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
